// File: rtl/alu_fu.sv
// Single-cycle RV32I integer functional unit: combinational decode/execute
// feeding one output register stage, tagged with the destination preg.
module alu_fu #(
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [31:0]       source_1,
    input  logic [31:0]       source_2,
    input  logic [PREG_W-1:0] dest,
    output logic [31:0]       result,
    output logic [PREG_W-1:0] result_dest,
    output logic              result_valid,
    output logic              illegal
);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] F7_Z   = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    logic [31:0]       result_q, result_d;
    logic [PREG_W-1:0] dest_q;
    logic              valid_q, illegal_q, illegal_d;

    logic [31:0] imm, opb;
    logic [4:0]  shamt;
    logic        is_imm;

    assign imm    = {{20{source_2[11]}}, source_2[11:0]};
    assign shamt  = source_2[4:0];
    assign is_imm = (opcode == OP_IMM);
    // OP-IMM and OP share one datapath; only the second operand differs.
    assign opb    = is_imm ? imm : source_2;

    always_comb begin
        result_d  = '0;
        illegal_d = 1'b0;
        case (opcode)
            OP_LD, OP_ST: result_d = source_1 + imm;
            OP_IMM, OP_REG: begin
                case (func3)
                    3'b000: begin
                        if (is_imm || func7 == F7_Z) result_d = source_1 + opb;
                        else if (func7 == F7_ALT)    result_d = source_1 - opb;
                        else                         illegal_d = 1'b1;
                    end
                    3'b001: begin
                        if (func7 == F7_Z) result_d = source_1 << shamt;
                        else               illegal_d = 1'b1;
                    end
                    3'b101: begin
                        if (func7 == F7_Z)        result_d = source_1 >> shamt;
                        else if (func7 == F7_ALT) result_d = 32'($signed(source_1) >>> shamt);
                        else                      illegal_d = 1'b1;
                    end
                    default: begin
                        // Remaining R-type ops only accept func7 = 0; I-type ignores it.
                        if (!is_imm && func7 != F7_Z) illegal_d = 1'b1;
                        else begin
                            case (func3)
                                3'b010:  result_d = {31'b0, $signed(source_1) < $signed(opb)};
                                3'b011:  result_d = {31'b0, source_1 < opb};
                                3'b100:  result_d = source_1 ^ opb;
                                3'b110:  result_d = source_1 | opb;
                                default: result_d = source_1 & opb;
                            endcase
                        end
                    end
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            dest_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= in_valid;
            illegal_q <= in_valid & illegal_d;
            if (in_valid) begin
                result_q <= result_d;
                dest_q   <= dest;
            end
        end
    end

    assign result       = result_q;
    assign result_dest  = dest_q;
    assign result_valid = valid_q;
    assign illegal      = illegal_q;
endmodule

// File: tb/tb_alu_fu.sv
// Self-checking bench for alu_fu: directed cases plus randomized issue
// compared against a behavioural RV32I model.
module tb_alu_fu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] source_1, source_2;
    logic [5:0]  dest;
    logic [31:0] result;
    logic [5:0]  result_dest;
    logic        result_valid, illegal;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_res;
    logic [5:0]  exp_dest;

    alu_fu #(.PREG_W(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
        .func3(func3), .func7(func7), .source_1(source_1), .source_2(source_2),
        .dest(dest), .result(result), .result_dest(result_dest),
        .result_valid(result_valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Reference: decide legality first, then evaluate the operation.
    function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill);
        logic signed [31:0] sa, sb;
        logic [31:0] ub;
        int sh;
        bit legal;
        sa = a;
        sh = int'(b[4:0]);
        r = 0;
        if (op == 7'h13) begin ub = {{20{b[11]}}, b[11:0]}; end
        else ub = b;
        sb = ub;
        legal = 1'b0;
        if (op == 7'h03 || op == 7'h23) legal = 1'b1;
        else if (op == 7'h13)
            legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                    (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else if (op == 7'h33)
            legal = (f3 == 3'd0 || f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : (f7 == 7'h00);
        ill = !legal;
        if (!legal) return;
        if (op == 7'h03 || op == 7'h23) begin
            r = a + {{20{b[11]}}, b[11:0]};
            return;
        end
        case (f3)
            3'd0: r = (op == 7'h33 && f7 == 7'h20) ? a - ub : a + ub;
            3'd1: r = a << sh;
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < ub) ? 32'd1 : 32'd0;
            3'd4: r = a ^ ub;
            3'd5: r = (f7 == 7'h20) ? 32'(sa >>> sh) : a >> sh;
            3'd6: r = a | ub;
            default: r = a & ub;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] d);
        @(negedge clk);
        in_valid = v; opcode = op; func3 = f3; func7 = f7;
        source_1 = a; source_2 = b; dest = d;
    endtask

    // Fire one op (or a bubble), then check outputs just after the capturing edge.
    task automatic issue(input string tag, input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] d);
        logic [31:0] r;
        logic ill;
        model(op, f3, f7, a, b, r, ill);
        drive(v, op, f3, f7, a, b, d);
        @(posedge clk); #1;
        if (v) begin
            exp_res = r; exp_dest = d;
        end
        chk({tag, ".valid"}, 64'(result_valid), 64'(v));
        chk({tag, ".illegal"}, 64'(illegal), 64'(v & ill));
        chk({tag, ".result"}, 64'(result), 64'(exp_res));
        chk({tag, ".dest"}, 64'(result_dest), 64'(exp_dest));
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; opcode = 0; func3 = 0; func7 = 0;
        source_1 = 0; source_2 = 0; dest = 0;
        exp_res = 0; exp_dest = 0;
        #12;
        chk("reset.valid", 64'(result_valid), 64'd0);
        chk("reset.result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Reset mid-operation
        issue("pre_rst_add", 1, 7'h33, 3'd0, 7'h00, 32'd1, 32'd1, 6'd3);
        #2 rst = 1'b1; #1;
        chk("rst_async.result", 64'(result), 64'd0);
        chk("rst_async.valid", 64'(result_valid), 64'd0);
        chk("rst_async.dest", 64'(result_dest), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.result", 64'(result), 64'd0);
        chk("rst_hold.valid", 64'(result_valid), 64'd0);
        chk("rst_hold.illegal", 64'(illegal), 64'd0);
        @(negedge clk); rst = 1'b0;
        exp_res = 0; exp_dest = 0;

        issue("addi", 1, 7'h13, 3'd0, 7'h00, 32'd5, 32'h00000FFF, 6'd9);
        chk("addi.const", 64'(result), 64'h4);
        issue("andi", 1, 7'h13, 3'd7, 7'h00, 32'd5, 32'h00000FFF, 6'd9);
        chk("andi.const", 64'(result), 64'h5);
        issue("add", 1, 7'h33, 3'd0, 7'h00, 32'd3, 32'd5, 6'd1);
        chk("add.const", 64'(result), 64'h8);
        issue("sub", 1, 7'h33, 3'd0, 7'h20, 32'd3, 32'd5, 6'd2);
        chk("sub.const", 64'(result), 64'hFFFFFFFE);
        issue("xor", 1, 7'h33, 3'd4, 7'h00, 32'd3, 32'd5, 6'd3);
        chk("xor.const", 64'(result), 64'h6);
        issue("sra", 1, 7'h33, 3'd5, 7'h20, 32'h80000000, 32'h24, 6'd4);
        chk("sra.const", 64'(result), 64'hF8000000);
        issue("srl", 1, 7'h33, 3'd5, 7'h00, 32'h80000000, 32'h24, 6'd5);
        chk("srl.const", 64'(result), 64'h08000000);
        issue("sll", 1, 7'h33, 3'd1, 7'h00, 32'h80000000, 32'h24, 6'd6);
        chk("sll.const", 64'(result), 64'h0);
        issue("slt", 1, 7'h33, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 6'd7);
        chk("slt.const", 64'(result), 64'h1);
        issue("sltu", 1, 7'h33, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 6'd8);
        chk("sltu.const", 64'(result), 64'h0);
        issue("lw", 1, 7'h03, 3'd2, 7'h00, 32'h100, 32'hFF8, 6'd10);
        chk("lw.const", 64'(result), 64'hF8);
        issue("bad_op", 1, 7'h7F, 3'd0, 7'h00, 32'h1234, 32'h5678, 6'd11);
        chk("bad_op.illegal", 64'(illegal), 64'd1);
        chk("bad_op.result", 64'(result), 64'd0);
        issue("bad_f7", 1, 7'h33, 3'd4, 7'h20, 32'h1234, 32'h5678, 6'd12);
        chk("bad_f7.illegal", 64'(illegal), 64'd1);

        // Back-to-back issue then a bubble
        issue("b2b0", 1, 7'h33, 3'd6, 7'h00, 32'hF0, 32'h0F, 6'd20);
        issue("b2b1", 1, 7'h13, 3'd0, 7'h00, 32'd10, 32'hFFE, 6'd21);
        issue("b2b2", 1, 7'h23, 3'd2, 7'h55, 32'h2000, 32'hFFFFF004, 6'd22);
        chk("b2b2.const", 64'(result), 64'h2004);
        issue("bubble", 0, 7'h33, 3'd0, 7'h00, 32'd7, 32'd7, 6'd30);
        chk("bubble.held", 64'(result), 64'h2004);

        // Randomized issue
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op, f7;
            int k;
            k = $urandom_range(0, 9);
            op = (k < 3) ? 7'h13 : (k < 6) ? 7'h33 : (k == 6) ? 7'h03 :
                 (k == 7) ? 7'h23 : 7'($urandom);
            k = $urandom_range(0, 4);
            f7 = (k < 2) ? 7'h00 : (k < 4) ? 7'h20 : 7'($urandom);
            issue("rand", ($urandom_range(0, 4) != 0), op, 3'($urandom), f7,
                  $urandom, $urandom, 6'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
